// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies
// and the result bundle passed from the datapath to the sequencer.
`default_nettype none
package md_unit_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef struct packed {
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  function automatic logic is_md_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_calc.sv
// Combinational 64-bit multiply/divide datapath producing the HI/LO result
// and a divide-by-zero flag for the selected operation.
`default_nettype none
module md_calc
  import md_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_result_t  res
);

  logic        signed_div;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] prod;

  always_comb begin
    // Signed division runs on magnitudes; this also makes 0x80000000 / -1
    // wrap to 0x80000000 with a zero remainder.
    signed_div = (op == MD_DIV);
    neg_a      = signed_div & a[31];
    neg_b      = signed_div & b[31];
    mag_a      = neg_a ? -a : a;
    mag_b      = neg_b ? -b : b;
    divisor    = (b == 32'd0) ? 32'd1 : mag_b;
    quo        = mag_a / divisor;
    rem        = mag_a % divisor;

    case (op)
      MD_MULT:  prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MD_MULTU: prod = {32'd0, a} * {32'd0, b};
      default:  prod = 64'd0;
    endcase

    res          = '0;
    res.div_zero = is_md_div(op) && (b == 32'd0);
    if (is_md_div(op)) begin
      res.lo = (neg_a ^ neg_b) ? -quo : quo;
      res.hi = neg_a ? -rem : rem;
    end else begin
      {res.hi, res.lo} = prod;
    end
  end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: fixed-latency mult/div sequencing and the
// architectural HI/LO registers with mthi/mtlo writes.
`default_nettype none
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_tmp_q, hi_tmp_d;
  logic [31:0]      lo_tmp_q, lo_tmp_d;
  logic             dz_q, dz_d;
  md_result_t       calc_res;

  md_calc u_calc (
    .op  (md_op),
    .a   (A),
    .b   (B),
    .res (calc_res)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    dz_d     = dz_q;

    if (!cancel && md_op == MD_MTHI) hi_d = A;
    if (!cancel && md_op == MD_MTLO) lo_d = A;

    case (state_q)
      S_IDLE: begin
        if (start && !cancel && is_md_arith(md_op)) begin
          state_d  = S_RUN;
          hi_tmp_d = calc_res.hi;
          lo_tmp_d = calc_res.lo;
          dz_d     = calc_res.div_zero;
          cnt_d    = is_md_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      default: begin
        // Commit is placed after the mt* writes so the finished result wins.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (!dz_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      dz_q     <= dz_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit with a cycle-level reference model.
`default_nettype none
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .A      (A),
    .B      (B),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural behaviour from plain integer arithmetic.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pdz;
  int          m_left;

  function automatic logic [64:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    logic [31:0]     rh, rl;
    sa = a;
    sb = b;
    rh = 32'd0;
    rl = 32'd0;
    if (op == 3'd1) begin
      sp = longint'(sa) * longint'(sb);
      return {1'b0, sp[63:32], sp[31:0]};
    end
    if (op == 3'd2) begin
      up = longint'({32'd0, a}) * longint'({32'd0, b});
      return {1'b0, up[63:32], up[31:0]};
    end
    if (b == 32'd0) return {1'b1, 64'd0};
    if (op == 3'd3) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        rl = 32'h8000_0000;
        rh = 32'd0;
      end else begin
        rl = sa / sb;
        rh = sa % sb;
      end
    end else begin
      rl = a / b;
      rh = a % b;
    end
    return {1'b0, rh, rl};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_phi  <= 32'd0;
      m_plo  <= 32'd0;
      m_pdz  <= 1'b0;
      m_left <= 0;
    end else begin
      if (!cancel && md_op == 3'd5) m_hi <= A;
      if (!cancel && md_op == 3'd6) m_lo <= A;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1 && !m_pdz) begin
          m_hi <= m_phi;
          m_lo <= m_plo;
        end
      end else if (start && !cancel && md_op >= 3'd1 && md_op <= 3'd4) begin
        m_left <= (md_op <= 3'd2) ? 5 : 10;
        {m_pdz, m_phi, m_plo} <= model_result(md_op, A, B);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("busy_vs_model", {31'd0, busy}, {31'd0, (m_left > 0)});
    check("hi_vs_model", hi, m_hi);
    check("lo_vs_model", lo, m_lo);
  end

  // Called at a negedge; drives one cycle of md_op and returns at the next negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cxl);
    start  = (op >= 3'd1 && op <= 3'd4);
    md_op  = op;
    A      = a;
    B      = b;
    cancel = cxl;
    @(negedge clk);
    start  = 1'b0;
    md_op  = 3'd0;
    A      = 32'd0;
    B      = 32'd0;
    cancel = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  int nb;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    count_busy(nb);
    check("mult_busy_cycles", nb, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    count_busy(nb);
    check("multu_busy_cycles", nb, 32'd5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    count_busy(nb);
    check("div_busy_cycles", nb, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'd5, 32'h11, 32'd0, 1'b0);
    issue(3'd6, 32'h22, 32'd0, 1'b0);
    check("mthi", hi, 32'h11);
    check("mtlo", lo, 32'h22);
    issue(3'd4, 32'd7, 32'd0, 1'b0);
    count_busy(nb);
    check("divu_by_zero_busy", nb, 32'd10);
    check("divu_by_zero_hi", hi, 32'h11);
    check("divu_by_zero_lo", lo, 32'h22);

    issue(3'd3, 32'd9, 32'd4, 1'b0);
    issue(3'd1, 32'd2, 32'd2, 1'b0);
    count_busy(nb);
    check("start_in_run_busy_rest", nb, 32'd9);
    check("start_in_run_lo", lo, 32'd2);
    check("start_in_run_hi", hi, 32'd1);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy(nb);
    check("div_ovf_busy", nb, 32'd10);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    issue(3'd1, 32'd3, 32'd3, 1'b1);
    check("cancel_start_busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'hABCD, 32'd0, 1'b1);
    check("cancel_mtlo_lo", lo, 32'h8000_0000);
    check("cancel_hi", hi, 32'd0);

    issue(3'd2, 32'd5, 32'd6, 1'b0);
    issue(3'd5, 32'h55, 32'd0, 1'b0);
    check("mthi_in_run", hi, 32'h55);
    count_busy(nb);
    check("mthi_in_run_busy_rest", nb, 32'd4);
    check("commit_over_mthi_hi", hi, 32'd0);
    check("commit_over_mthi_lo", lo, 32'd30);

    issue(3'd1, 32'd4, 32'd5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_hi", hi, 32'd0);
    check("mid_reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_hi", hi, 32'd0);
    check("post_reset_lo", lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
